// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle core:
// opcodes, functs, FSM states and field positions.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [2:0] F_ADD = 3'd0;
   localparam logic [2:0] F_SUB = 3'd1;
   localparam logic [2:0] F_AND = 3'd2;
   localparam logic [2:0] F_OR  = 3'd3;
   localparam logic [2:0] F_XOR = 3'd4;
   localparam logic [2:0] F_SLT = 3'd5;
   localparam logic [2:0] F_SLL = 3'd6;
   localparam logic [2:0] F_SRL = 3'd7;

   localparam int OP_LSB  = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int FN_LSB  = 0;
   localparam int IMM_LSB = 0;
   localparam int JI_LSB  = 0;

   function automatic logic op_known(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
                        OP_ADDI, OP_LW, OP_SW};
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two async read ports, one sync write.
// Register 0 always reads as zero and ignores writes.
module mc_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   localparam int RW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RW-1:0]     ra_a,
   input  logic [RW-1:0]     ra_b,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   input  logic              we,
   input  logic [RW-1:0]     wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs [NREGS];

   assign rd_a = (ra_a == '0) ? '0 : regs[ra_a];
   assign rd_b = (ra_b == '0) ? '0 : regs[ra_b];

   // Clear on reset, write on the edge when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB sequenced
// by one FSM, req/ack instruction and data ports.
import cpu_pkg::*;

module multicycle_cpu #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int NREGS  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              instr_req,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic [31:0]       instr,
   input  logic              instr_ack,
   output logic              data_req,
   output logic              data_we,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_ack,
   output logic              retire,
   output logic              halted
);

   localparam int RW   = $clog2(NREGS);
   localparam int SH_W = $clog2(DATA_W);
   localparam logic [ADDR_W-1:0] JMASK =
      ADDR_W'(28'hFFF_FFFF);

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       ir;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] simm_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] mdr_q;

   logic [5:0]        op;
   logic [2:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       jidx;
   logic [RW-1:0]     rs_idx;
   logic [RW-1:0]     rt_idx;
   logic [RW-1:0]     rd_idx;

   logic [DATA_W-1:0] rf_a;
   logic [DATA_W-1:0] rf_b;
   logic              rf_we;
   logic [RW-1:0]     rf_wa;
   logic [DATA_W-1:0] rf_wd;

   logic [DATA_W-1:0] alu_res;
   logic [SH_W-1:0]   shamt;
   logic              is_ctrl;
   logic              is_mem;
   logic              take_br;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] j_tgt;

   assign op     = ir[OP_LSB +: 6];
   assign funct  = ir[FN_LSB +: 3];
   assign imm    = ir[IMM_LSB +: 16];
   assign jidx   = ir[JI_LSB +: 26];
   assign rs_idx = ir[RS_LSB +: RW];
   assign rt_idx = ir[RT_LSB +: RW];
   assign rd_idx = ir[RD_LSB +: RW];

   assign is_ctrl = op inside {OP_BEQ, OP_BNE, OP_J};
   assign is_mem  = (op == OP_LW) || (op == OP_SW);

   assign instr_addr = pc;

   // SW completes on the data ack itself, so retire
   // cannot be a registered flag without an extra cycle.
   assign retire = (state == S_WB)
                || (state == S_EXEC && is_ctrl)
                || (state == S_MEM && data_req
                    && data_ack && data_we);

   assign rf_we = (state == S_WB);
   assign rf_wa = (op == OP_RTYPE) ? rd_idx : rt_idx;
   assign rf_wd = (op == OP_LW) ? mdr_q : alu_q;

   mc_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_rf (
      .clk   (clk),
      .rst_n (rst),
      .ra_a  (rs_idx),
      .ra_b  (rt_idx),
      .rd_a  (rf_a),
      .rd_b  (rf_b),
      .we    (rf_we),
      .wa    (rf_wa),
      .wd    (rf_wd)
   );

   assign shamt = a_q[SH_W-1:0];

   // ALU: R-type by funct, everything else A + SIMM.
   always_comb begin
      alu_res = a_q + simm_q;
      if (op == OP_RTYPE) begin
         unique case (funct)
            F_ADD: alu_res = a_q + b_q;
            F_SUB: alu_res = a_q - b_q;
            F_AND: alu_res = a_q & b_q;
            F_OR:  alu_res = a_q | b_q;
            F_XOR: alu_res = a_q ^ b_q;
            F_SLT: alu_res = {{(DATA_W-1){1'b0}},
                              $signed(a_q) < $signed(b_q)};
            F_SLL: alu_res = b_q << shamt;
            F_SRL: alu_res = b_q >> shamt;
         endcase
      end
   end

   // Control-flow targets; PC already points past IR.
   always_comb begin
      take_br = (op == OP_BEQ) ? (a_q == b_q)
                               : (a_q != b_q);
      br_tgt  = pc + (simm_q[ADDR_W-1:0] << 2);
      j_tgt   = (pc & ~JMASK)
              | ADDR_W'({jidx, 2'b00});
   end

   // Main sequencer with registered bus outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         ir        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         simm_q    <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         instr_req <= 1'b0;
         data_req  <= 1'b0;
         data_we   <= 1'b0;
         data_addr <= '0;
         data_out  <= '0;
         halted    <= 1'b0;
      end else begin
         unique case (state)
            S_FETCH: begin
               if (!instr_req) begin
                  instr_req <= 1'b1;
               end else if (instr_ack) begin
                  ir        <= instr;
                  pc        <= pc + ADDR_W'(4);
                  instr_req <= 1'b0;
                  state     <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q    <= rf_a;
               b_q    <= rf_b;
               simm_q <= {{(DATA_W-16){imm[15]}}, imm};
               if (op_known(op)) begin
                  state <= S_EXEC;
               end else begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end
            end
            S_EXEC: begin
               alu_q <= alu_res;
               unique case (1'b1)
                  is_ctrl: begin
                     if (op == OP_J)
                        pc <= j_tgt;
                     else if (take_br)
                        pc <= br_tgt;
                     instr_req <= 1'b1;
                     state     <= S_FETCH;
                  end
                  is_mem: begin
                     data_req  <= 1'b1;
                     data_we   <= (op == OP_SW);
                     data_addr <= alu_res[ADDR_W-1:0];
                     data_out  <= b_q;
                     state     <= S_MEM;
                  end
                  default: state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (data_ack) begin
                  data_req <= 1'b0;
                  data_we  <= 1'b0;
                  mdr_q    <= data_in;
                  if (data_we) begin
                     instr_req <= 1'b1;
                     state     <= S_FETCH;
                  end else begin
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               instr_req <= 1'b1;
               state     <= S_FETCH;
            end
            S_HALT: begin
               halted <= 1'b1;
            end
            default: begin
               halted <= 1'b1;
               state  <= S_HALT;
            end
         endcase
      end
   end

endmodule
